// File: rtl/cv32e40p_apu_arbiter.sv
// Round-robin arbiter sharing one FP APU between NUM_REQ requesters.
// In-order ID FIFO routes responses; issue is restricted to one latency class while busy.
module cv32e40p_apu_arbiter #(
    parameter int unsigned NUM_REQ          = 2,
    parameter int unsigned DEPTH            = 4,
    parameter int unsigned ID_W             = $clog2(NUM_REQ),
    parameter int unsigned APU_NARGS_CPU    = 3,
    parameter int unsigned APU_WOP_CPU      = 6,
    parameter int unsigned APU_NDSFLAGS_CPU = 15,
    parameter int unsigned APU_NUSFLAGS_CPU = 5
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic [NUM_REQ-1:0]                            req_i,
    output logic [NUM_REQ-1:0]                            gnt_o,
    input  logic [NUM_REQ-1:0][APU_NARGS_CPU-1:0][31:0]   operands_i,
    input  logic [NUM_REQ-1:0][APU_WOP_CPU-1:0]           op_i,
    input  logic [NUM_REQ-1:0][APU_NDSFLAGS_CPU-5:0]      flags_i,
    input  logic [NUM_REQ-1:0][1:0]                       lat_class_i,
    output logic [NUM_REQ-1:0]                            rvalid_o,
    output logic [31:0]                                   rdata_o,
    output logic [APU_NUSFLAGS_CPU-1:0]                   rflags_o,
    output logic                                          apu_req_o,
    input  logic                                          apu_gnt_i,
    output logic [APU_NARGS_CPU-1:0][31:0]                apu_operands_o,
    output logic [APU_WOP_CPU-1:0]                        apu_op_o,
    output logic [APU_NDSFLAGS_CPU-5:0]                   apu_flags_o,
    input  logic                                          apu_rvalid_i,
    input  logic [31:0]                                   apu_rdata_i,
    input  logic [APU_NUSFLAGS_CPU-1:0]                   apu_rflags_i,
    output logic                                          resp_err_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);
    localparam logic [AW-1:0] LastIdx  = AW'(DEPTH - 1);

    logic [ID_W-1:0]            ptr_q, ptr_d;
    logic [DEPTH-1:0][ID_W-1:0] fifo_q;
    logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              count_q, count_d;
    logic [1:0]                 cur_class_q, cur_class_d;
    logic                       err_q, err_d;

    logic [ID_W-1:0] sel;
    logic            any_req, space, class_ok, issue_ok, hs;
    logic            pop, bypass, push, spurious, empty;

    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base,
                                               input int unsigned   off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LastIdx) ? '0 : p + AW'(1);
    endfunction

    // Walk downwards so the closest requester at or after ptr_q wins last.
    always_comb begin
        sel = ptr_q;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[rr_idx(ptr_q, unsigned'(i))]) sel = rr_idx(ptr_q, unsigned'(i));
        end
    end

    assign empty    = (count_q == '0);
    assign any_req  = |req_i;
    assign space    = (count_q != DepthCnt) || apu_rvalid_i;
    // Registered count only: a same-cycle pop never relaxes the class check.
    assign class_ok = empty || (lat_class_i[sel] == cur_class_q);
    assign issue_ok = rst_ni && any_req && space && class_ok;
    assign hs       = issue_ok && apu_gnt_i;

    assign pop      = apu_rvalid_i && !empty;
    assign bypass   = apu_rvalid_i && empty && hs;
    assign spurious = apu_rvalid_i && empty && !hs;
    assign push     = hs && !bypass;

    assign apu_req_o      = issue_ok;
    assign apu_operands_o = operands_i[sel];
    assign apu_op_o       = op_i[sel];
    assign apu_flags_o    = flags_i[sel];
    assign rdata_o        = apu_rdata_i;
    assign rflags_o       = apu_rflags_i;
    assign resp_err_o     = err_q;

    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        if (hs) gnt_o[sel] = 1'b1;
        if (rst_ni) begin
            if (pop) begin
                rvalid_o[fifo_q[rd_ptr_q]] = 1'b1;
            end else if (bypass) begin
                rvalid_o[sel] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        cur_class_d = cur_class_q;
        err_d       = err_q;
        if (hs) begin
            ptr_d       = rr_idx(sel, 1);
            cur_class_d = lat_class_i[sel];
        end
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (spurious) err_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q       <= '0;
            fifo_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cur_class_q <= '0;
            err_q       <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cur_class_q <= cur_class_d;
            err_q       <= err_d;
            if (push) fifo_q[wr_ptr_q] <= sel;
        end
    end

endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// Self-checking bench for cv32e40p_apu_arbiter: directed scenarios then random traffic,
// compared each cycle against a queue-based model of the arbitration rules.
module tb_cv32e40p_apu_arbiter;

    localparam int NR  = 2;
    localparam int D   = 4;
    localparam int NA  = 3;
    localparam int WOP = 6;
    localparam int NDS = 15;
    localparam int NUS = 5;

    logic                         clk, rst_n;
    logic [NR-1:0]                req, gnt, rvalid;
    logic [NR-1:0][NA-1:0][31:0]  operands;
    logic [NR-1:0][WOP-1:0]       op;
    logic [NR-1:0][NDS-5:0]       flags;
    logic [NR-1:0][1:0]           lat_class;
    logic [31:0]                  rdata, apu_rdata;
    logic [NUS-1:0]               rflags, apu_rflags;
    logic                         apu_req, apu_gnt, apu_rvalid, resp_err;
    logic [NA-1:0][31:0]          apu_operands;
    logic [WOP-1:0]               apu_op;
    logic [NDS-5:0]               apu_flags;

    cv32e40p_apu_arbiter #(.NUM_REQ(NR), .DEPTH(D)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_i          (req),
        .gnt_o          (gnt),
        .operands_i     (operands),
        .op_i           (op),
        .flags_i        (flags),
        .lat_class_i    (lat_class),
        .rvalid_o       (rvalid),
        .rdata_o        (rdata),
        .rflags_o       (rflags),
        .apu_req_o      (apu_req),
        .apu_gnt_i      (apu_gnt),
        .apu_operands_o (apu_operands),
        .apu_op_o       (apu_op),
        .apu_flags_o    (apu_flags),
        .apu_rvalid_i   (apu_rvalid),
        .apu_rdata_i    (apu_rdata),
        .apu_rflags_i   (apu_rflags),
        .resp_err_o     (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: outstanding owners in issue order, RR pointer, class, sticky error.
    int owners[$];
    int m_ptr = 0;
    int m_cur = 0;
    bit m_err = 0;

    // FPU model: due cycle of each accepted op; fpu_zero hands rvalid to the directed steps.
    int unsigned lat_tab[4];
    int          fpu_q[$];
    bit          fpu_zero = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic cycle();
        int sel, cnt;
        bit any, space, cls_ok, issue, hs, rv;
        logic [NR-1:0] e_gnt, e_rv;
        for (int r = 0; r < NR; r++) begin
            for (int a = 0; a < NA; a++) operands[r][a] = $urandom;
            op[r]    = WOP'($urandom);
            flags[r] = (NDS-4)'($urandom);
        end
        apu_rdata  = $urandom;
        apu_rflags = NUS'($urandom);
        if (!fpu_zero) begin
            apu_rvalid = 1'b0;
            if (fpu_q.size() > 0 && fpu_q[0] <= cyc) begin
                apu_rvalid = 1'b1;
                void'(fpu_q.pop_front());
            end
        end
        #1;
        rv  = apu_rvalid;
        cnt = owners.size();
        any = |req;
        sel = 0;
        for (int i = NR - 1; i >= 0; i--) if (req[(m_ptr + i) % NR]) sel = (m_ptr + i) % NR;
        space  = (cnt < D) || rv;
        cls_ok = (cnt == 0) || (int'(lat_class[sel]) == m_cur);
        issue  = any && space && cls_ok;
        hs     = issue && apu_gnt;
        e_gnt  = '0;
        if (hs) e_gnt[sel] = 1'b1;
        e_rv = '0;
        if (rv && cnt > 0) e_rv[owners[0]] = 1'b1;
        else if (rv && hs) e_rv[sel] = 1'b1;

        check("apu_req", 128'(apu_req), 128'(issue));
        check("gnt", 128'(gnt), 128'(e_gnt));
        check("rvalid", 128'(rvalid), 128'(e_rv));
        check("resp_err", 128'(resp_err), 128'(m_err));
        check("count", 128'(dut.count_q), 128'(cnt));
        check("ptr", 128'(dut.ptr_q), 128'(m_ptr));
        check("rdata", 128'(rdata), 128'(apu_rdata));
        check("rflags", 128'(rflags), 128'(apu_rflags));
        if (issue) begin
            check("operands", 128'(apu_operands), 128'(operands[sel]));
            check("op", 128'(apu_op), 128'(op[sel]));
            check("flags", 128'(apu_flags), 128'(flags[sel]));
        end
        if (!fpu_zero) begin
            for (int k = 0; k < NR; k++) if (gnt[k]) fpu_q.push_back(cyc + int'(lat_tab[lat_class[k]]));
        end

        @(posedge clk);
        if (rv && cnt == 0 && !hs) m_err = 1'b1;
        if (rv && cnt > 0) void'(owners.pop_front());
        if (hs && !(rv && cnt == 0)) owners.push_back(sel);
        if (hs) begin
            m_cur = int'(lat_class[sel]);
            m_ptr = (sel + 1) % NR;
        end
        cyc++;
        @(negedge clk);
    endtask

    // Asserts reset between edges with traffic present; outputs must drop at once.
    task automatic do_reset();
        req        = '1;
        apu_gnt    = 1'b1;
        apu_rvalid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_apu_req", 128'(apu_req), 128'(0));
        check("rst_gnt", 128'(gnt), 128'(0));
        check("rst_rvalid", 128'(rvalid), 128'(0));
        check("rst_err", 128'(resp_err), 128'(0));
        owners.delete();
        m_ptr = 0;
        m_cur = 0;
        m_err = 0;
        apu_rvalid = 1'b0;
        req        = '0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b1;
        req        = '0;
        lat_class  = '0;
        apu_gnt    = 1'b1;
        apu_rvalid = 1'b0;
        apu_rdata  = '0;
        apu_rflags = '0;
        operands   = '0;
        op         = '0;
        flags      = '0;
        lat_tab[0] = 2; lat_tab[1] = 11; lat_tab[2] = 1; lat_tab[3] = 2;
        do_reset();

        // Idle after reset
        req = '0;
        repeat (2) cycle();

        // Fairness: both requesters on ADDMUL, latency 2
        req = 2'b11;
        lat_class = '0;
        repeat (8) cycle();
        req = '0;
        repeat (4) cycle();

        // Class stall: DIVSQRT from 0, then ADDMUL from 1 waits for the drain
        req = 2'b01;
        lat_class[0] = 2'd1;
        cycle();
        req = 2'b10;
        lat_class[1] = 2'd0;
        repeat (16) cycle();
        req = '0;
        repeat (4) cycle();

        // FIFO full: latency 6, single streaming requester
        lat_tab[0] = 6;
        lat_class = '0;
        req = 2'b01;
        repeat (14) cycle();
        req = '0;
        repeat (8) cycle();
        lat_tab[0] = 2;

        // Zero-latency bypass from requester 1
        fpu_zero   = 1;
        req        = 2'b10;
        apu_gnt    = 1'b1;
        apu_rvalid = 1'b1;
        cycle();
        apu_rvalid = 1'b0;
        req        = '0;
        cycle();

        // Spurious response, then stickiness
        apu_rvalid = 1'b1;
        cycle();
        apu_rvalid = 1'b0;
        fpu_zero   = 0;
        repeat (3) cycle();

        // Backpressure then reset with two DIVSQRT ops in flight
        do_reset();
        req = 2'b11;
        lat_class = '0;
        apu_gnt = 1'b0;
        repeat (3) cycle();
        apu_gnt = 1'b1;
        lat_class = {2'd1, 2'd1};
        repeat (2) cycle();
        req = '0;
        cycle();
        do_reset();
        repeat (15) cycle();
        do_reset();

        // Random traffic with the standard latency table
        for (int n = 0; n < 600; n++) begin
            req = NR'($urandom);
            for (int r = 0; r < NR; r++)
                lat_class[r] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            apu_gnt = ($urandom_range(0, 3) != 0);
            cycle();
        end
        req = '0;
        repeat (15) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
